clk_gate_ctrl: RTL and testbench

Controller for the system's clock-gating cell: it decides when the gated clock domain, e.g. the ALU, must run and drives the gating cell's enable input. Requesters hold a level request, and the controller grants access only after the gated clock has run for a fixed wake-up interval. It keeps the clock alive for a programmable idle hysteresis before shutting it off, which avoids enable chatter. Sits in the always-on domain next to the system controller, clocked by the reference clock that feeds the gating cell.

---
 rtl/clk_gate_ctrl_if.sv | 22 ++
 rtl/clk_gate_ctrl.sv | 105 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// Requester-side bundle of the clock-gate controller: level requests and
// per-requester acks, plus the gating-cell enable and status outputs.
interface clk_gate_ctrl_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0] req;
   logic               force_on;
   logic               clk_en;
   logic [NUM_REQ-1:0] ack;
   logic               gate_active;
   logic [7:0]         wake_count;

   modport master (
      output req, force_on,
      input  clk_en, ack, gate_active, wake_count
   );

   modport slave (
      input  req, force_on,
      output clk_en, ack, gate_active, wake_count
   );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable sequencer: wakes the gated domain for a fixed interval
// before acking, and holds it alive for an idle hysteresis after requests drop.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | gated clock stopped, clk_en low
// WAKE  | clk_en high, counting down the wake-up interval, no ack
// ON    | clock stable, ack follows req
// HOLD  | no request, clk_en kept high for the idle interval, no ack
module clk_gate_ctrl #(
   parameter int NUM_REQ  = 2,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 4,
   parameter int CNT_W    = 4
) (
   input logic            clk,
   input logic            rst_n,
   clk_gate_ctrl_if.slave bus
);

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_WAKE = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_en_q, clk_en_d;
   logic [7:0]       wake_count_q, wake_count_d;
   logic             any_req;

   always_comb begin
      any_req      = (|bus.req) | bus.force_on;
      state_d      = state_q;
      cnt_d        = cnt_q;
      wake_count_d = wake_count_q;
      case (state_q)
         S_OFF: begin
            if (any_req) begin
               state_d = S_WAKE;
               cnt_d   = WAKE_LOAD;
               if (wake_count_q != 8'hFF) begin
                  wake_count_d = wake_count_q + 8'd1;
               end
            end
         end
         S_WAKE: begin
            // wake runs to completion even if every request has gone away
            if (cnt_q == '0) begin
               state_d = S_ON;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_ON: begin
            if (!any_req) begin
               if (IDLE_CYC == 0) begin
                  state_d = S_OFF;
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = IDLE_LOAD;
               end
            end
         end
         S_HOLD: begin
            // a request on the last hold cycle still wins over shutting off
            if (any_req) begin
               state_d = S_ON;
            end else if (cnt_q == '0) begin
               state_d = S_OFF;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase
      clk_en_d = (state_d != S_OFF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_OFF;
         cnt_q        <= '0;
         clk_en_q     <= 1'b0;
         wake_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clk_en_q     <= clk_en_d;
         wake_count_q <= wake_count_d;
      end
   end

   assign bus.ack         = (state_q == S_ON) ? bus.req : '0;
   assign bus.clk_en      = clk_en_q;
   assign bus.gate_active = clk_en_q;
   assign bus.wake_count  = wake_count_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: default-config instance (a) and a fast config
// instance (b, WAKE_CYC=1, IDLE_CYC=0), driven from per-edge state timelines.
module tb_clk_gate_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   clk_gate_ctrl_if #(.NUM_REQ(2)) if_a ();
   clk_gate_ctrl_if #(.NUM_REQ(2)) if_b ();

   clk_gate_ctrl #(.NUM_REQ(2), .WAKE_CYC(2), .IDLE_CYC(4), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a));
   clk_gate_ctrl #(.NUM_REQ(2), .WAKE_CYC(1), .IDLE_CYC(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b));

   typedef struct {
      logic       clk_en;
      logic [1:0] ack;
      logic [7:0] wc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   wc_exp[2];
   logic sel = 1'b0;

   logic       cur_clk_en, cur_ga;
   logic [1:0] cur_ack;
   logic [7:0] cur_wc;
   always_comb begin
      cur_clk_en = sel ? if_b.clk_en      : if_a.clk_en;
      cur_ga     = sel ? if_b.gate_active : if_a.gate_active;
      cur_ack    = sel ? if_b.ack         : if_a.ack;
      cur_wc     = sel ? if_b.wake_count  : if_a.wake_count;
   end

   task automatic set_in(input logic [1:0] r, input logic f);
      if (sel) begin
         if_b.req = r; if_b.force_on = f;
      end else begin
         if_a.req = r; if_a.force_on = f;
      end
   endtask

   // st_s holds the state expected after each edge: F=OFF W=WAKE O=ON H=HOLD
   task automatic run_timeline(input logic s, input logic [1:0] mask, input string req_s,
                               input string frc_s, input string st_s, input string name);
      exp_t e, got;
      byte  prev;
      logic r, f;
      logic [1:0] want_ack;
      sel  = s;
      prev = "F";
      for (int i = 0; i < st_s.len(); i++) begin
         r = (req_s[i] == "1");
         f = (frc_s[i] == "1");
         set_in(r ? mask : 2'b00, f);
         #1;
         want_ack = (prev == "O" && r) ? mask : 2'b00;
         checks++;
         if (cur_ack !== want_ack) begin
            errors++;
            $display("FAIL %s comb_ack edge %0d: got %b want %b", name, i + 1, cur_ack, want_ack);
         end
         if (st_s[i] == "W" && prev == "F") wc_exp[s] = (wc_exp[s] < 255) ? wc_exp[s] + 1 : 255;
         e.clk_en = (st_s[i] != "F");
         e.ack    = (st_s[i] == "O" && r) ? mask : 2'b00;
         e.wc     = 8'(wc_exp[s]);
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         got = exp_q.pop_front();
         checks++;
         if (cur_clk_en !== got.clk_en || cur_ga !== got.clk_en) begin
            errors++;
            $display("FAIL %s clk_en edge %0d: got %b/%b want %b", name, i + 1, cur_clk_en, cur_ga, got.clk_en);
         end
         checks++;
         if (cur_ack !== got.ack) begin
            errors++;
            $display("FAIL %s ack edge %0d: got %b want %b", name, i + 1, cur_ack, got.ack);
         end
         checks++;
         if (cur_wc !== got.wc) begin
            errors++;
            $display("FAIL %s wake_count edge %0d: got %0d want %0d", name, i + 1, cur_wc, got.wc);
         end
         prev = st_s[i];
      end
      set_in(2'b00, 1'b0);
   endtask

   task automatic test_reset();
      sel = 1'b0;
      if_a.req = 2'b11; if_a.force_on = 1'b0;
      if_b.req = 2'b00; if_b.force_on = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (if_a.clk_en !== 1'b0 || if_a.gate_active !== 1'b0 || if_a.ack !== 2'b00 || if_a.wake_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_hold: got clk_en=%b ga=%b ack=%b wc=%0d want 0 0 00 0",
                  if_a.clk_en, if_a.gate_active, if_a.ack, if_a.wake_count);
      end
      wc_exp[0] = 0;
      wc_exp[1] = 0;
      @(negedge clk) rst_n = 1'b1;
      run_timeline(1'b0, 2'b11, "1111000000", "0000000000", "WWOOHHHHFF", "reset_release");
   endtask

   task automatic test_wake_hold();
      run_timeline(1'b0, 2'b01, "1111111000000", "0000000000000", "WWOOOOOHHHHFF", "wake_hold");
   endtask

   task automatic test_rerequest();
      run_timeline(1'b0, 2'b10, "11110011000011000000", "00000000000000000000",
                   "WWOOHHOOHHHHOOHHHHFF", "rerequest");
   endtask

   task automatic test_drop_during_wake();
      run_timeline(1'b0, 2'b01, "1000000000", "0000000000", "WWOHHHHFFF", "drop_wake_a");
      run_timeline(1'b1, 2'b01, "1000", "0000", "WOFF", "drop_wake_b");
   endtask

   task automatic test_fast_cfg();
      run_timeline(1'b1, 2'b10, "1100", "0000", "WOFF", "fast_short");
      run_timeline(1'b1, 2'b11, "1110", "0000", "WOOF", "fast_long");
   endtask

   task automatic test_force_on();
      run_timeline(1'b0, 2'b11, "00000000000000000000000000", "11111111111111111111000000",
                   "WWOOOOOOOOOOOOOOOOOOHHHHFF", "force_on");
   endtask

   task automatic test_async_reset();
      sel = 1'b0;
      set_in(2'b01, 1'b0);
      repeat (4) @(posedge clk);
      #1 set_in(2'b00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (if_a.clk_en !== 1'b1) begin
         errors++;
         $display("FAIL async_pre_hold clk_en: got %b want 1", if_a.clk_en);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (if_a.clk_en !== 1'b0 || if_a.gate_active !== 1'b0 || if_a.ack !== 2'b00 || if_a.wake_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got clk_en=%b ga=%b ack=%b wc=%0d want 0 0 00 0",
                  if_a.clk_en, if_a.gate_active, if_a.ack, if_a.wake_count);
      end
      checks++;
      if (if_b.wake_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_b wc: got %0d want 0", if_b.wake_count);
      end
      wc_exp[0] = 0;
      wc_exp[1] = 0;
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (if_a.clk_en !== 1'b0) begin
         errors++;
         $display("FAIL async_post_idle clk_en: got %b want 0", if_a.clk_en);
      end
   endtask

   task automatic test_wake_saturate();
      exp_t e, got;
      sel = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         set_in(2'b01, 1'b0);
         wc_exp[1] = (wc_exp[1] < 255) ? wc_exp[1] + 1 : 255;
         e.clk_en = 1'b0;
         e.ack    = 2'b00;
         e.wc     = 8'(wc_exp[1]);
         exp_q.push_back(e);
         @(posedge clk);
         #1 set_in(2'b00, 1'b0);
         repeat (2) @(posedge clk);
         #1;
         got = exp_q.pop_front();
         checks++;
         if (cur_wc !== got.wc || cur_clk_en !== got.clk_en) begin
            errors++;
            $display("FAIL saturate wake %0d: got wc=%0d clk_en=%b want wc=%0d clk_en=%b",
                     i, cur_wc, cur_clk_en, got.wc, got.clk_en);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wc_exp[0] = 0;
      wc_exp[1] = 0;
      test_reset();
      test_wake_hold();
      test_rerequest();
      test_drop_during_wake();
      test_fast_cfg();
      test_force_on();
      test_async_reset();
      test_wake_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
